// File: rtl/cb_cfg_pkg.sv
// Shared types and sizing for the control connection block config loader.
package cb_cfg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} cb_state_e;

  localparam int CB_W         = 8;
  localparam int CB_CONTROLIN = 6;

  function automatic int cb_nbits(input int w, input int ci);
    return w * ci;
  endfunction
endpackage

// File: rtl/onehot0_check.sv
// Flags a switch group as legal when at most one of its enables is set.
module onehot0_check #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic         ok
);
  // Clearing the lowest set bit leaves zero only for popcount <= 1.
  assign ok = ((vec & (vec - N'(1))) == '0);
endmodule

// File: rtl/cb_config_loader.sv
// Serial bitstream loader: shifts into a shadow register, then commits to the
// switch-enable bus only when every control input's group is at-most-one-hot.
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter  int W         = CB_W,
  parameter  int CONTROLIN = CB_CONTROLIN,
  localparam int NBITS     = cb_nbits(W, CONTROLIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_chain_out,
  output logic [NBITS-1:0] c,
  output logic             cfg_done,
  output logic             cfg_err
);
  localparam int CW = $clog2(NBITS + 1);

  cb_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0] c_q, c_d;
  logic             chain_q, chain_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CONTROLIN-1:0] grp_ok;
  logic                 all_ok;

  for (genvar g = 0; g < CONTROLIN; g++) begin : g_grp
    onehot0_check #(.N(W)) u_chk (
      .vec (shadow_q[g*W +: W]),
      .ok  (grp_ok[g])
    );
  end
  assign all_ok = &grp_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    chain_d  = chain_q;
    done_d   = done_q;
    err_d    = err_q;
    // A start wins over anything else, including a pending commit.
    if (cfg_start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (cfg_valid) begin
            shadow_d = {cfg_bit, shadow_q[NBITS-1:1]};
            chain_d  = shadow_q[0];
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(NBITS - 1)) state_d = CHECK;
          end
        end
        CHECK: begin
          if (all_ok) begin
            c_d    = shadow_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      chain_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      chain_q  <= chain_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready     = (state_q == SHIFT);
  assign cfg_chain_out = chain_q;
  assign c             = c_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
endmodule

// File: tb/tb_cb_config_loader.sv
// Bench for cb_config_loader: table of whole-image loads, hand-written corner
// sequences, and randomized traffic checked every cycle against a queue model.
module tb_cb_config_loader;
  localparam int NBITS = 48;

  logic             clk = 1'b0;
  logic             rst = 1'b1, cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic             cfg_ready, cfg_chain_out, cfg_done, cfg_err;
  logic [NBITS-1:0] c;

  cb_config_loader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_valid     (cfg_valid),
    .cfg_bit       (cfg_bit),
    .cfg_ready     (cfg_ready),
    .cfg_chain_out (cfg_chain_out),
    .c             (c),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: hist holds the last NBITS accepted bits, oldest first (zeros after reset).
  bit               m_load, m_pend, m_done, m_err, m_chain;
  int               m_cnt;
  logic [NBITS-1:0] m_c;
  bit               hist[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic m_reset();
    m_load = 0; m_pend = 0; m_done = 0; m_err = 0; m_chain = 0; m_cnt = 0;
    m_c = '0;
    hist.delete();
    for (int i = 0; i < NBITS; i++) hist.push_back(1'b0);
  endtask

  task automatic m_commit();
    logic [NBITS-1:0] img;
    bit ok;
    for (int i = 0; i < NBITS; i++) img[i] = hist[i];
    ok = 1;
    for (int g = 0; g < 6; g++) if ($countones(img[g*8 +: 8]) > 1) ok = 0;
    if (ok) begin m_c = img; m_done = 1; end
    else m_err = 1;
    m_pend = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input bit r, input bit s, input bit v, input bit b);
    rst = r; cfg_start = s; cfg_valid = v; cfg_bit = b;
    @(posedge clk);
    if (r) m_reset();
    else if (s) begin m_load = 1; m_cnt = 0; m_done = 0; m_err = 0; m_pend = 0; end
    else if (m_pend) m_commit();
    else if (m_load && v) begin
      hist.push_back(b);
      m_chain = hist.pop_front();
      m_cnt++;
      if (m_cnt == NBITS) begin m_load = 0; m_pend = 1; end
    end
    #1;
    chk("ready", cfg_ready, m_load);
    chk("chain", cfg_chain_out, m_chain);
    chk("c", c, m_c);
    chk("done", cfg_done, m_done);
    chk("err", cfg_err, m_err);
  endtask

  task automatic load(input logic [NBITS-1:0] img, input int gap_pct,
                      output logic [NBITS-1:0] seen);
    int k = 0;
    int guard = 0;
    bit v;
    seen = '0;
    cyc(0, 1, 0, 0);
    while (k < NBITS && guard < 5000) begin
      v = ($urandom_range(99) >= gap_pct);
      cyc(0, 0, v, img[k]);
      if (v) begin seen[k] = cfg_chain_out; k++; end
      guard++;
    end
    if (k < NBITS) chk("load_timeout", k, NBITS);
    cyc(0, 0, 0, 0);
  endtask

  function automatic logic [NBITS-1:0] rand_clean();
    logic [NBITS-1:0] img = '0;
    int k;
    for (int g = 0; g < 6; g++) begin
      k = $urandom_range(8);
      if (k < 8) img[g*8 + k] = 1'b1;
    end
    return img;
  endfunction

  typedef struct {
    logic [NBITS-1:0] img;
    int               gap;
    logic [NBITS-1:0] exp_c;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  vec_t             tbl[6];
  logic [NBITS-1:0] seen, img_a, img_b;

  initial begin
    m_reset();
    // Reset held two cycles with valid high.
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 0);
    chk("rst_c", c, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_chain", cfg_chain_out, 0);

    tbl[0] = '{48'h8000_0000_0008,  0, 48'h8000_0000_0008, 1, 0};
    tbl[1] = '{48'h0000_0003_0000,  0, 48'h8000_0000_0008, 0, 1};
    tbl[2] = '{48'h0000_0000_0000, 30, 48'h0000_0000_0000, 1, 0};
    tbl[3] = '{48'h2010_0804_0201, 20, 48'h2010_0804_0201, 1, 0};
    tbl[4] = '{48'h8100_0000_0000, 10, 48'h2010_0804_0201, 0, 1};
    tbl[5] = '{48'h0000_0000_00FF,  0, 48'h2010_0804_0201, 0, 1};
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].img, tbl[i].gap, seen);
      chk($sformatf("tbl%0d_c", i), c, tbl[i].exp_c);
      chk($sformatf("tbl%0d_done", i), cfg_done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_ready", i), cfg_ready, 0);
    end

    // Valid bits in IDLE are ignored; gapped load yields the clean image.
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1'($urandom_range(1)));
    chk("idle_ready", cfg_ready, 0);
    load(48'h8000_0000_0008, 50, seen);
    chk("gap_c", c, 48'h8000_0000_0008);
    chk("gap_done", cfg_done, 1);

    // Restart after 20 accepts; the bit alongside the start is dropped.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    img_a = 48'h0001_0020_4080;
    for (int i = 0; i < NBITS - 1; i++) cyc(0, 0, 1, img_a[i]);
    chk("restart_ready47", cfg_ready, 1);
    chk("restart_done47", cfg_done, 0);
    cyc(0, 0, 1, img_a[NBITS-1]);
    chk("restart_ready48", cfg_ready, 0);
    cyc(0, 0, 0, 0);
    chk("restart_c", c, img_a);
    chk("restart_done", cfg_done, 1);

    // Reset after 30 accepts, asserted together with a start.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 1);
    cyc(1, 1, 1, 1);
    chk("midrst_c", c, 0);
    chk("midrst_ready", cfg_ready, 0);
    cyc(0, 0, 1, 1);
    chk("midrst_idle", cfg_ready, 0);

    // Chain: during B's accepts the chain output replays A in order.
    img_a = 48'h1234_5678_9ABC;
    img_b = {16'($urandom), 32'($urandom)};
    load(img_a, 0, seen);
    load(img_b, 25, seen);
    chk("chain_replay", seen, img_a);

    // Random clean loads with random gaps.
    for (int r = 0; r < 10; r++) begin
      img_b = rand_clean();
      load(img_b, $urandom_range(60), seen);
      chk("rand_clean_c", c, img_b);
    end

    // Free-running random traffic including restarts and resets.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(299) == 0, $urandom_range(79) == 0,
          1'($urandom_range(1)), 1'($urandom_range(1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cb_config_loader.md
# cb_config_loader

Serial configuration loader for one control connection block tile. It accepts a bitstream one bit per valid/ready handshake into a shadow register and checks each control input's switch group for at-most-one-hot. Only a clean image is committed to the parallel switch-enable bus `c`, which drives the control connection block's transmission gates. A serial chain output lets tiles be daisy-chained.

## Interface
- `W`, 8: routing tracks per channel (switches per control input).
- `CONTROLIN`, 6: control inputs per block.
- `NBITS`, `W*CONTROLIN`: derived; configuration bits per block; not overridden.
- `clk` input 1: sole clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cfg_start` input 1: one-cycle pulse that begins or restarts a load.
- `cfg_valid` input 1: `cfg_bit` is valid this cycle.
- `cfg_bit` input 1: serial configuration data, LSB of `c` first.
- `cfg_ready` output 1: loader accepts a bit this cycle.
- `cfg_chain_out` output 1: bit shifted out of the shadow register, for the next tile.
- `c` output NBITS: committed switch enables; bit `j+i*W` connects track `j` to control input `i`.
- `cfg_done` output 1: level; last load committed successfully.
- `cfg_err` output 1: level; last load rejected (a group had more than one bit set).

## Operation
- States:
  - IDLE: `cfg_ready`=0.
  - SHIFT: `cfg_ready`=1.
  - CHECK: `cfg_ready`=0, lasts one cycle.
- IDLE → SHIFT on `cfg_start`:
  - bit counter cleared to 0.
  - `cfg_done` and `cfg_err` cleared.
  - `c` keeps its old value.
- SHIFT, on `cfg_valid && cfg_ready` (an accept):
  - shadow ← {`cfg_bit`, shadow[NBITS-1:1]}.
  - `cfg_chain_out` ← old shadow[0].
  - counter +1.
  - After NBITS accepts, the first bit sits in shadow[0].
- SHIFT → CHECK on the accept that brings the counter to NBITS. Cycles with `cfg_valid`=0 do nothing; gaps of any length are legal.
- `cfg_start` during SHIFT or CHECK:
  - counter cleared, state becomes SHIFT.
  - `cfg_done` and `cfg_err` cleared.
  - shadow not cleared.
  - `c` unchanged.
  - `cfg_start` takes priority over an accept in the same cycle; that bit is dropped.
- CHECK evaluates groups i = 0..CONTROLIN-1, each group being shadow[i*W +: W]:
  - If every group has zero or one bit set: `c` ← shadow, `cfg_done` ← 1.
  - Otherwise: `cfg_err` ← 1 and `c` is held.
  - Then → IDLE.
- All-zero groups are legal (control input left floating).
- `cfg_valid` while in IDLE or CHECK is ignored.
- Counter width is `$clog2(NBITS+1)`. It never exceeds NBITS.
- Reset values:
  - state IDLE, counter 0, shadow 0.
  - `c`=0 (all switches open).
  - `cfg_chain_out`=0, `cfg_done`=0, `cfg_err`=0.
  - `cfg_ready`=0.

## Timing
- `cfg_ready` is a decode of the registered state only. It has no combinational path from `cfg_valid` or `cfg_start`.
- Accept at edge k with the counter reaching NBITS:
  - state is CHECK in cycle k+1.
  - `c`, `cfg_done` and `cfg_err` update at edge k+1, and the state is IDLE from then.
  - `cfg_ready` is 0 in the cycle after the last accept.
- A new `cfg_start` is accepted in any state, including the cycle right after commit.
- `cfg_chain_out` changes only on accepts. A bit entering at accept n leaves at accept n+NBITS (shadow acts as an NBITS-deep delay).
- `rst` asserted mid-load:
  - all state returns to reset values at that edge.
  - `c` goes to 0 even if a prior image was committed.
  - `rst` dominates `cfg_start`.
- `c` never changes except at a CHECK edge or a reset edge, so there are no partial images on the switch bus.

## Structure
- Package `cb_cfg_pkg` holds:
  - the state enum (IDLE, SHIFT, CHECK).
  - the defaults `CB_W`=8 and `CB_CONTROLIN`=6.
  - the function `cb_nbits(w, ci)` returning w*ci.
- Sub-module `onehot0_check #(N)`: input `vec[N-1:0]`, output `ok`, which is 1 when popcount ≤ 1. It is purely combinational and instantiated CONTROLIN times with N=W. The loader ANDs the `ok` outputs.

## Test plan
- Reset: assert `rst` for 2 cycles with `cfg_valid`=1 → `c`=0, `cfg_ready`=0, `cfg_done`=0, `cfg_err`=0, `cfg_chain_out`=0.
- Clean load (W=8, CONTROLIN=6): pulse `cfg_start`, then 48 consecutive accepts with only bit 3 and bit 8*5+7 set → `c`=48'h8000_0000_0008 one cycle after the last accept, `cfg_done`=1, `cfg_ready`=0.
- One-hot violation: a 48-bit image with bits 16 and 17 set (group 2) → `cfg_err`=1, `cfg_done`=0, `c` still equals the previous image.
- Gapped valid: the same clean image with `cfg_valid` toggling pseudo-randomly, plus 10 invalid bits driven in IDLE before `cfg_start` → identical `c` as the clean load.
- Restart and reset mid-load:
  - After 20 accepts, pulse `cfg_start` with `cfg_valid`=1 → that bit is dropped, and a full 48 further accepts are needed before CHECK.
  - Separately, `rst` after 30 accepts → `c`=0 and state IDLE.
- Chain out: load image A then image B → during B's accepts, `cfg_chain_out` reproduces A's bits in order, each one cycle after its accept.
